d5m_i2c_slave: RTL and testbench
================================

D5M_I2C_SLAVE -- requirements
Module: d5m_i2c_slave

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h5D, 7-bit device address answered (write byte 8'hBA, read byte 8'hBB).
REQ-002 SHALL have port clk  input  1  system clock; sole clock, all logic on posedge clk.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port i2c_clk  input  1  SCL from the bus master; not used as a clock.
REQ-005 SHALL have port i2c_data  inout  1  SDA; driven only as 1'b0 or 1'bz, never 1'b1.
REQ-006 SHALL have port wr_en  output  1  one-clk write strobe.
REQ-007 SHALL have port wr_addr  output  8  register address of the write.
REQ-008 SHALL have port wr_data  output  16  register data of the write.
REQ-009 SHALL have port rd_addr  output  8  current register pointer, for read lookup.
REQ-010 SHALL have port rd_data  input  16  register contents at rd_addr, sampled combinationally.
REQ-011 SHALL have port busy  output  1  high from START detection until STOP or return to IDLE.

Function
REQ-012 SHALL pass i2c_clk and i2c_data through 2-flop synchronizers and detect edges on the synchronized values; SCL period SHALL be at least 16 clk cycles.
REQ-013 SHALL detect START as SDA falling while SCL high and STOP as SDA rising while SCL high, in any state.
REQ-014 SHALL sample SDA on synchronized SCL rising edges and change its own SDA drive only on synchronized SCL falling edges.
REQ-015 SHALL use states IDLE, DEV, ACK_DEV, REG, ACK_REG, MSB, ACK_MSB, LSB, ACK_LSB, RD_MSB, RACK_MSB, RD_LSB, RACK_LSB, WAIT_STOP.
REQ-016 START SHALL move any state to DEV with bit counter cleared; a repeated START SHALL keep the register pointer.
REQ-017 STOP SHALL move any state to IDLE, release SDA and drop busy.
REQ-018 In DEV, after 8 bits: address match with R/W=0 -> ACK_DEV then REG; mismatch -> SDA released (NACK), WAIT_STOP.
REQ-019 An ACK state SHALL drive SDA low from the SCL falling edge after the 8th bit to the next SCL falling edge.
REQ-020 REG byte SHALL load the register pointer (rd_addr); MSB byte then LSB byte form the 16-bit word {MSB,LSB}.
REQ-021 wr_en SHALL pulse exactly one clk, 1 clk after the SCL rising edge that samples the LSB's 8th bit; wr_addr/wr_data SHALL hold until the next write.
REQ-022 After ACK_LSB a further byte SHALL be taken as MSB of the next word; the pointer SHALL increment after each write, 8'hFF wrapping to 8'h00.
REQ-023 A START or STOP before the LSB completes SHALL discard the partial word with no wr_en.
REQ-024 Outputs SHALL remain valid and stable while no transaction is in progress.

Reset
REQ-025 rst SHALL asynchronously force IDLE, SDA released (1'bz), wr_en=0, wr_addr=8'h00, wr_data=16'h0000, rd_addr=8'h00, busy=0, synchronizers to 1.
REQ-026 Reset mid-transfer SHALL release SDA immediately; the next access SHALL begin only at a fresh START.

Configuration
REQ-027 With D5M_I2C_SLAVE_READ_EN defined, DEV matching with R/W=1 SHALL ACK and enter RD_MSB: shift rd_data[15:8] then rd_data[7:0] MSB-first, driving 0 as low and 1 as z; master ACK after LSB increments pointer (wrap 8'hFF->8'h00) and continues; master NACK -> WAIT_STOP.
REQ-028 Without D5M_I2C_SLAVE_READ_EN, R/W=1 SHALL be treated as a mismatch (NACK, WAIT_STOP) and read states SHALL not be built.

Verification
REQ-029 Write 8'hBA,8'h09,8'h07,8'hC0, STOP -> four ACKs; one wr_en with wr_addr=8'h09, wr_data=16'h07C0; busy low after STOP.
REQ-030 Write 8'h90,... -> SDA never driven; no wr_en; state WAIT_STOP until STOP.
REQ-031 Write 8'hBA,8'hFF,8'h12,8'h34,8'h56,8'h78 -> wr_en (8'hFF,16'h1234) then (8'h00,16'h5678).
REQ-032 rst asserted during the ACK of REG byte -> SDA z same cycle, all outputs at reset values; later full write 8'h20,16'hC000 succeeds.
REQ-033 READ_EN: write 8'hBA,8'hA0, repeated START, 8'hBB with rd_data=16'hA5C3, master NACK on 2nd byte -> bytes 8'hA5,8'hC3 observed; rd_addr=8'hA0; no wr_en.
REQ-034 No READ_EN: 8'hBB after START -> NACK, no SDA drive until STOP.

Source files
------------

// File: rtl/d5m_i2c_slave.sv
// d5m_i2c_slave: I2C register-write slave oversampled on clk; define D5M_I2C_SLAVE_READ_EN to add register reads
module d5m_i2c_slave #(
    parameter logic [6:0] DEV_ADDR = 7'h5D
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i2c_clk,
    inout  wire         i2c_data,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic [7:0]  rd_addr,
    input  logic [15:0] rd_data,
    output logic        busy
);
    typedef enum logic [3:0] {
        IDLE, DEV, ACK_DEV, REG, ACK_REG, MSB, ACK_MSB, LSB, ACK_LSB, WAIT_STOP
`ifdef D5M_I2C_SLAVE_READ_EN
        , RD_MSB, RACK_MSB, RD_LSB, RACK_LSB
`endif
    } state_t;

    state_t      state, state_next;
    logic [1:0]  scl_sync, sda_sync;
    logic        scl_prev, sda_prev;
    logic [3:0]  cnt, cnt_next;
    logic [7:0]  shift, shift_next, msb, msb_next, rd_addr_next, wr_addr_next;
    logic [15:0] wr_data_next;
    logic        oe, oe_next, wr_en_next;

    logic scl, sda, scl_rise, scl_fall, start, stop, byte_done, match;
    assign scl       = scl_sync[1];
    assign sda       = sda_sync[1];
    assign scl_rise  = scl & ~scl_prev;
    assign scl_fall  = ~scl & scl_prev;
    assign start     = scl & scl_prev & sda_prev & ~sda;
    assign stop      = scl & scl_prev & ~sda_prev & sda;
    assign byte_done = cnt == 4'd8;
`ifdef D5M_I2C_SLAVE_READ_EN
    assign match     = shift[7:1] == DEV_ADDR;
`else
    assign match     = shift == {DEV_ADDR, 1'b0};
    logic unused_rd;
    assign unused_rd = ^rd_data;
`endif
    assign i2c_data  = oe ? 1'b0 : 1'bz;
    assign busy      = state != IDLE;

    // synchronizers, edge history and all protocol state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
            state    <= IDLE;
            cnt      <= 4'd0;
            shift    <= 8'h00;
            msb      <= 8'h00;
            oe       <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= 8'h00;
            wr_data  <= 16'h0000;
            rd_addr  <= 8'h00;
        end else begin
            scl_sync <= {scl_sync[0], i2c_clk};
            sda_sync <= {sda_sync[0], i2c_data};
            scl_prev <= scl;
            sda_prev <= sda;
            state    <= state_next;
            cnt      <= cnt_next;
            shift    <= shift_next;
            msb      <= msb_next;
            oe       <= oe_next;
            wr_en    <= wr_en_next;
            wr_addr  <= wr_addr_next;
            wr_data  <= wr_data_next;
            rd_addr  <= rd_addr_next;
        end
    end

    // bus conditions first; bits sampled on SCL rise, SDA drive changed only on SCL fall
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        shift_next   = shift;
        msb_next     = msb;
        oe_next      = oe;
        wr_en_next   = 1'b0;
        wr_addr_next = wr_addr;
        wr_data_next = wr_data;
        rd_addr_next = rd_addr;
        if (stop) begin
            state_next = IDLE;
            oe_next    = 1'b0;
        end else if (start) begin
            state_next = DEV;
            cnt_next   = 4'd0;
            oe_next    = 1'b0;
        end else if (scl_rise) begin
            case (state)
                DEV, REG, MSB, LSB: begin
                    shift_next = {shift[6:0], sda};
                    cnt_next   = cnt + 4'd1;
                end
`ifdef D5M_I2C_SLAVE_READ_EN
                RD_MSB, RD_LSB: cnt_next = cnt + 4'd1;
                RACK_LSB: begin
                    shift_next[0] = sda;
                    rd_addr_next  = sda ? rd_addr : rd_addr + 8'd1;
                end
`endif
                default: ;
            endcase
            if (state == LSB && cnt == 4'd7) begin
                wr_en_next   = 1'b1;
                wr_addr_next = rd_addr;
                wr_data_next = {msb, shift[6:0], sda};
                rd_addr_next = rd_addr + 8'd1;
            end
        end else if (scl_fall) begin
            case (state)
                DEV: if (byte_done) begin
                    cnt_next   = 4'd0;
                    state_next = match ? ACK_DEV : WAIT_STOP;
                    oe_next    = match;
                end
                ACK_DEV: begin
                    oe_next    = 1'b0;
                    state_next = REG;
`ifdef D5M_I2C_SLAVE_READ_EN
                    if (shift[0]) begin
                        state_next = RD_MSB;
                        shift_next = rd_data[15:8];
                        oe_next    = ~rd_data[15];
                    end
`endif
                end
                REG: if (byte_done) begin
                    rd_addr_next = shift;
                    cnt_next     = 4'd0;
                    state_next   = ACK_REG;
                    oe_next      = 1'b1;
                end
                MSB: if (byte_done) begin
                    msb_next   = shift;
                    cnt_next   = 4'd0;
                    state_next = ACK_MSB;
                    oe_next    = 1'b1;
                end
                LSB: if (byte_done) begin
                    cnt_next   = 4'd0;
                    state_next = ACK_LSB;
                    oe_next    = 1'b1;
                end
                ACK_REG, ACK_LSB: begin
                    oe_next    = 1'b0;
                    state_next = MSB;
                end
                ACK_MSB: begin
                    oe_next    = 1'b0;
                    state_next = LSB;
                end
`ifdef D5M_I2C_SLAVE_READ_EN
                RD_MSB, RD_LSB: if (byte_done) begin
                    cnt_next   = 4'd0;
                    oe_next    = 1'b0;
                    state_next = state == RD_MSB ? RACK_MSB : RACK_LSB;
                end else begin
                    shift_next = {shift[6:0], 1'b0};
                    oe_next    = ~shift[6];
                end
                RACK_MSB: begin
                    state_next = RD_LSB;
                    shift_next = rd_data[7:0];
                    oe_next    = ~rd_data[7];
                end
                RACK_LSB: begin
                    state_next = shift[0] ? WAIT_STOP : RD_MSB;
                    shift_next = rd_data[15:8];
                    oe_next    = ~shift[0] & ~rd_data[15];
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_d5m_i2c_slave.sv
// tb_d5m_i2c_slave: bit-banged I2C master with a write-event scoreboard for d5m_i2c_slave
module tb_d5m_i2c_slave;
    localparam int Q = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl = 1'b1;
    logic        m_low = 1'b0;
    wire         sda;
    logic        wr_en, busy;
    logic [7:0]  wr_addr, rd_addr;
    logic [15:0] wr_data, rd_data;
    int          n_tests = 0;
    int          n_fail = 0;
    int          drive_cnt = 0;
    logic [23:0] exp_q[$];

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;
    assign rd_data = (rd_addr == 8'hA0) ? 16'hA5C3 : 16'h1E2D;

    d5m_i2c_slave dut (
        .clk(clk), .rst(rst), .i2c_clk(scl), .i2c_data(sda),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // scoreboard monitor: every write strobe pops one expected event; also counts slave SDA drive
    always @(negedge clk) begin
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wr_unexpected: got addr %h data %h, required no write", wr_addr, wr_data);
            end else begin
                chk("wr_event", {8'h00, wr_addr, wr_data}, {8'h00, exp_q.pop_front()});
            end
        end
        if (!rst && sda === 1'b0 && !m_low) drive_cnt++;
    end

    task automatic i2c_start();
        m_low = 1'b1; #Q;
        scl = 1'b0; #Q;
    endtask

    task automatic i2c_rstart();
        m_low = 1'b0; #Q;
        scl = 1'b1; #Q;
        m_low = 1'b1; #Q;
        scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; #Q;
        scl = 1'b1; #Q;
        m_low = 1'b0; #Q;
    endtask

    task automatic bit_w(input logic b);
        m_low = ~b; #Q;
        scl = 1'b1; #(2 * Q);
        scl = 1'b0; #Q;
    endtask

    task automatic bit_r(output logic b);
        m_low = 1'b0; #Q;
        scl = 1'b1; #Q;
        b = (sda !== 1'b0); #Q;
        scl = 1'b0; #Q;
    endtask

    task automatic byte_w(input logic [7:0] v, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) bit_w(v[i]);
        bit_r(b);
        ack = ~b;
    endtask

    task automatic byte_r(output logic [7:0] v, input logic ack);
        for (int i = 7; i >= 0; i--) bit_r(v[i]);
        bit_w(~ack);
    endtask

    initial begin
        logic       a;
        logic [7:0] rb;
        #2;
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {16'd0, wr_data}, 32'd0);
        chk("rst_rd_addr", {24'd0, rd_addr}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sda", {31'd0, sda}, 32'd1);
        #21 rst = 1'b0;
        #(2 * Q);

        // plain single-word write
        i2c_start();
        chk("t1_busy", {31'd0, busy}, 32'd1);
        byte_w(8'hBA, a); chk("t1_ack_dev", {31'd0, a}, 32'd1);
        byte_w(8'h09, a); chk("t1_ack_reg", {31'd0, a}, 32'd1);
        byte_w(8'h07, a); chk("t1_ack_msb", {31'd0, a}, 32'd1);
        exp_q.push_back({8'h09, 16'h07C0});
        byte_w(8'hC0, a); chk("t1_ack_lsb", {31'd0, a}, 32'd1);
        i2c_stop(); #Q;
        chk("t1_busy_after_stop", {31'd0, busy}, 32'd0);
        chk("t1_rd_addr", {24'd0, rd_addr}, 32'h0A);
        chk("t1_hold", {8'd0, wr_addr, wr_data}, 32'h0009_07C0);

        // wrong address: never driven, no write
        i2c_start();
        drive_cnt = 0;
        byte_w(8'h90, a); chk("t2_nack_dev", {31'd0, a}, 32'd0);
        byte_w(8'h09, a); chk("t2_nack_next", {31'd0, a}, 32'd0);
        chk("t2_busy_wait_stop", {31'd0, busy}, 32'd1);
        i2c_stop(); #Q;
        chk("t2_no_drive", drive_cnt, 32'd0);
        chk("t2_busy_after_stop", {31'd0, busy}, 32'd0);

        // two words with pointer wrap
        i2c_start();
        byte_w(8'hBA, a);
        byte_w(8'hFF, a);
        exp_q.push_back({8'hFF, 16'h1234});
        byte_w(8'h12, a);
        byte_w(8'h34, a);
        exp_q.push_back({8'h00, 16'h5678});
        byte_w(8'h56, a); chk("t3_ack_second_msb", {31'd0, a}, 32'd1);
        byte_w(8'h78, a); chk("t3_ack_second_lsb", {31'd0, a}, 32'd1);
        i2c_stop(); #Q;
        chk("t3_rd_addr_wrap", {24'd0, rd_addr}, 32'h01);

        // partial word cut by repeated START: discarded, pointer kept
        i2c_start();
        byte_w(8'hBA, a);
        byte_w(8'h30, a);
        byte_w(8'h11, a);
        for (int i = 0; i < 4; i++) bit_w(i[0]);
        i2c_rstart();
        byte_w(8'hBA, a); chk("t4_ack_after_rstart", {31'd0, a}, 32'd1);
        i2c_stop(); #Q;
        chk("t4_rd_addr_kept", {24'd0, rd_addr}, 32'h30);
        chk("t4_hold", {8'd0, wr_addr, wr_data}, 32'h0000_5678);

        // reset during ACK of the register byte
        i2c_start();
        byte_w(8'hBA, a);
        for (int i = 7; i >= 0; i--) bit_w(i == 5);
        m_low = 1'b0; #Q;
        chk("t5_ack_driven", {31'd0, sda}, 32'd0);
        rst = 1'b1; #1;
        chk("t5_sda_released", {31'd0, sda}, 32'd1);
        chk("t5_outputs_reset", {6'd0, wr_en, busy, wr_addr, wr_data}, 32'd0);
        chk("t5_rd_addr_reset", {24'd0, rd_addr}, 32'd0);
        #(Q - 1) rst = 1'b0;
        scl = 1'b1; #(2 * Q);
        scl = 1'b0; #Q;
        drive_cnt = 0;
        byte_w(8'hC0, a); chk("t5_no_start_nack", {31'd0, a}, 32'd0);
        byte_w(8'h00, a);
        i2c_stop(); #Q;
        chk("t5_no_drive", drive_cnt, 32'd0);
        i2c_start();
        byte_w(8'hBA, a);
        byte_w(8'h20, a);
        byte_w(8'hC0, a);
        exp_q.push_back({8'h20, 16'hC000});
        byte_w(8'h00, a); chk("t5_ack_lsb", {31'd0, a}, 32'd1);
        i2c_stop(); #Q;
        chk("t5_rd_addr", {24'd0, rd_addr}, 32'h21);

`ifdef D5M_I2C_SLAVE_READ_EN
        // pointer set by write, read back via repeated START
        i2c_start();
        byte_w(8'hBA, a);
        byte_w(8'hA0, a);
        i2c_rstart();
        byte_w(8'hBB, a); chk("t6_ack_read_dev", {31'd0, a}, 32'd1);
        byte_r(rb, 1'b1); chk("t6_read_msb", {24'd0, rb}, 32'hA5);
        byte_r(rb, 1'b0); chk("t6_read_lsb", {24'd0, rb}, 32'hC3);
        i2c_stop(); #Q;
        chk("t6_rd_addr", {24'd0, rd_addr}, 32'hA0);
`else
        // read request refused when reads are not built
        i2c_start();
        drive_cnt = 0;
        byte_w(8'hBB, a); chk("t6_nack_read", {31'd0, a}, 32'd0);
        byte_r(rb, 1'b0);
        chk("t6_busy", {31'd0, busy}, 32'd1);
        i2c_stop(); #Q;
        chk("t6_no_drive", drive_cnt, 32'd0);
        chk("t6_rd_addr", {24'd0, rd_addr}, 32'h21);
        chk("t6_read_byte_idle", {24'd0, rb}, 32'hFF);
`endif

        #(20 * Q);
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
